// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART byte transmitter between NUM_REQ byte-stream requesters
//   (0 = raw waveform dump, 1 = FIR waveform dump, 2 = command echo/status).
//   Grants are packet-locked and round-robin. The owner keeps the transmitter
//   until it hands over a byte flagged last, or until its req_valid stays low
//   for TIMEOUT cycles. The output side is a one-entry registered buffer.
// Ports
//   clk, rst             UART clock, synchronous active-high reset
//   req_valid/req_last   per-requester byte valid / end-of-packet flag
//   req_data             requester i byte at [i*DATA_W +: DATA_W]
//   req_ready            per-requester accept (only the owner ever sees 1)
//   tx_data/tx_valid     buffered byte to the serialiser
//   tx_ready             serialiser accepts when tx_valid && tx_ready
//   grant_id             current owner, or last owner while idle
//   busy                 high while a grant is held or its last byte drains
//   timeout_evt          one-cycle pulse on a forced (idle) release
module uart_tx_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_evt
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam logic [GID_W:0] NREQ = (GID_W+1)'(NUM_REQ);
  localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOCK, DRAIN} state_t;

  state_t                         state;
  logic [GID_W-1:0]               last_grant;
  logic [15:0]                    idle_cnt;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_bytes;
  logic [GID_W-1:0]               pick;
  logic                           any_req;
  logic [GID_W:0]                 cand;
  logic                           can_take;
  logic                           accept;
  logic                           own_valid;
  logic                           own_last;

  assign req_bytes = req_data;

  // Round-robin pick: walk offsets from NUM_REQ down to 1 so the smallest
  // offset after last_grant that is requesting ends up winning.
  always_comb begin
    pick    = last_grant;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last_grant} + (GID_W+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (req_valid[cand[GID_W-1:0]]) begin
        pick    = cand[GID_W-1:0];
        any_req = 1'b1;
      end
    end
  end

  // Buffer can take a byte when empty or emptying this cycle.
  assign can_take = !tx_valid || tx_ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign req_ready[i] = (state == LOCK) && (grant_id == GID_W'(i)) && can_take;
  end

  assign accept    = |(req_valid & req_ready);
  assign own_valid = req_valid[grant_id];
  assign own_last  = req_last[grant_id];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      last_grant  <= GID_W'(NUM_REQ - 1);
      idle_cnt    <= '0;
      busy        <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      // Drain the buffer on handshake; a same-cycle accept refills it.
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (accept) begin
        tx_data  <= req_bytes[grant_id];
        tx_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id   <= pick;
            last_grant <= pick;
            idle_cnt   <= '0;
            busy       <= 1'b1;
            state      <= LOCK;
          end
        end
        LOCK: begin
          // A last-byte accept implies req_valid was high, so it always
          // takes precedence over the idle timeout.
          if (accept && own_last) begin
            idle_cnt <= '0;
            state    <= DRAIN;
          end else if (accept || own_valid) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TO_M1) begin
            idle_cnt    <= '0;
            timeout_evt <= 1'b1;
            state       <= DRAIN;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        DRAIN: begin
          if (can_take) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
